// File: rtl/ad_ip_jesd204_tpl_adc_capture_ctrl.sv
// ---------------------------------------------------------------------------
// ad_ip_jesd204_tpl_adc_capture_ctrl
//
// Capture sequencer between the TPL ADC core and the DMA. A software arm
// optionally waits for a rising edge on adc_sync_in (with an optional
// timeout), then passes exactly cfg_capture_len link_valid beats to the DMA
// by gating the per-channel valids. Done/timeout are reported as sticky
// states until the next arm or abort.
//
// Ports:
//   clk, rst            core clock, async active-high reset
//   arm, abort          single-cycle control requests
//   cfg_ext_sync_en     wait for external sync edge before capturing
//   cfg_capture_len     beats to capture (sampled on arm)
//   cfg_timeout         max cycles in ARMED, 0 = forever (sampled on arm)
//   adc_sync_in         external sync, already in the clk domain
//   link_valid          beat qualifier from the link layer
//   adc_valid_in/out    per-channel valid from the core / gated to the DMA
//   sync_armed, capture_active, capture_done, timeout_err  state decodes
//   beat_count          beats captured so far
//   state_debug         raw state register
// ---------------------------------------------------------------------------
module ad_ip_jesd204_tpl_adc_capture_ctrl #(
    parameter int NUM_CHANNELS  = 1,
    parameter int LEN_WIDTH     = 32,
    parameter int TIMEOUT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     cfg_ext_sync_en,
    input  logic [LEN_WIDTH-1:0]     cfg_capture_len,
    input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
    input  logic                     adc_sync_in,
    input  logic                     link_valid,
    input  logic [NUM_CHANNELS-1:0]  adc_valid_in,
    output logic [NUM_CHANNELS-1:0]  adc_valid_out,
    output logic                     sync_armed,
    output logic                     capture_active,
    output logic                     capture_done,
    output logic                     timeout_err,
    output logic [LEN_WIDTH-1:0]     beat_count,
    output logic [2:0]               state_debug
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_TIMEOUT = 3'd4;

    localparam logic [LEN_WIDTH-1:0]     LEN_ONE = LEN_WIDTH'(1);
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_ONE = TIMEOUT_WIDTH'(1);

    logic [2:0]               state;
    logic                     sync_in_d1;
    logic                     sync_edge;
    logic [LEN_WIDTH-1:0]     len_q;
    logic [TIMEOUT_WIDTH-1:0] tmo_q;
    logic [TIMEOUT_WIDTH-1:0] wait_cnt;

    assign sync_edge = adc_sync_in & ~sync_in_d1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            sync_in_d1 <= 1'b0;
            len_q      <= '0;
            tmo_q      <= '0;
            wait_cnt   <= '0;
            beat_count <= '0;
        end else begin
            sync_in_d1 <= adc_sync_in;
            // abort beats everything, and leaves all counters untouched
            if (abort) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE, S_DONE, S_TIMEOUT: begin
                        if (arm) begin
                            len_q      <= cfg_capture_len;
                            tmo_q      <= cfg_timeout;
                            wait_cnt   <= '0;
                            beat_count <= '0;
                            if (cfg_capture_len == '0)
                                state <= S_DONE;
                            else if (cfg_ext_sync_en)
                                state <= S_ARMED;
                            else
                                state <= S_CAPTURE;
                        end
                    end
                    S_ARMED: begin
                        if (wait_cnt != '1)
                            wait_cnt <= wait_cnt + TMO_ONE;
                        // edge wins a tie with the timeout; wait_cnt counts
                        // completed ARMED cycles, so the compare against
                        // tmo_q-1 leaves after exactly tmo_q cycles
                        if (sync_edge)
                            state <= S_CAPTURE;
                        else if (tmo_q != '0 && wait_cnt == tmo_q - TMO_ONE)
                            state <= S_TIMEOUT;
                    end
                    S_CAPTURE: begin
                        if (link_valid) begin
                            beat_count <= beat_count + LEN_ONE;
                            if (beat_count == len_q - LEN_ONE)
                                state <= S_DONE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign sync_armed     = (state == S_ARMED);
    assign capture_active = (state == S_CAPTURE);
    assign capture_done   = (state == S_DONE);
    assign timeout_err    = (state == S_TIMEOUT);
    assign state_debug    = state;

    // Gate is combinational on registered state so the last beat that moves
    // the FSM to DONE still reaches the DMA.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        assign adc_valid_out[c] = capture_active & link_valid & adc_valid_in[c];
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_capture_ctrl.sv
module tb_ad_ip_jesd204_tpl_adc_capture_ctrl;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm, abort, cfg_ext_sync_en;
    logic [31:0] cfg_capture_len, cfg_timeout;
    logic        adc_sync_in, link_valid;
    logic [NCH-1:0] adc_valid_in, adc_valid_out;
    logic        sync_armed, capture_active, capture_done, timeout_err;
    logic [31:0] beat_count;
    logic [2:0]  state_debug;

    int checks = 0;
    int errors = 0;
    int vo_cnt = 0;

    always #5 clk = ~clk;

    ad_ip_jesd204_tpl_adc_capture_ctrl #(
        .NUM_CHANNELS(NCH), .LEN_WIDTH(32), .TIMEOUT_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort),
        .cfg_ext_sync_en(cfg_ext_sync_en), .cfg_capture_len(cfg_capture_len),
        .cfg_timeout(cfg_timeout), .adc_sync_in(adc_sync_in),
        .link_valid(link_valid), .adc_valid_in(adc_valid_in),
        .adc_valid_out(adc_valid_out), .sync_armed(sync_armed),
        .capture_active(capture_active), .capture_done(capture_done),
        .timeout_err(timeout_err), .beat_count(beat_count),
        .state_debug(state_debug)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phases of a capture, tracked as "how far along" rather than as an FSM:
    // remaining beats and elapsed wait cycles decide where we are.
    localparam int P_IDLE = 0, P_WAIT = 1, P_CAP = 2, P_DONE = 3, P_TMO = 4;
    int          m_phase;
    longint      m_len, m_tmo, m_waited, m_beats;
    logic        m_prev_sync;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = P_IDLE; m_len = 0; m_tmo = 0; m_waited = 0; m_beats = 0;
            m_prev_sync = 1'b0;
        end else begin
            bit edge_seen;
            edge_seen = adc_sync_in && !m_prev_sync;
            m_prev_sync = adc_sync_in;
            if (abort) m_phase = P_IDLE;
            else if (m_phase == P_WAIT) begin
                if (m_waited < 64'hFFFF_FFFF) m_waited++;
                if (edge_seen) m_phase = P_CAP;
                else if (m_tmo != 0 && m_waited == m_tmo) m_phase = P_TMO;
            end else if (m_phase == P_CAP) begin
                if (link_valid) begin
                    m_beats++;
                    if (m_beats == m_len) m_phase = P_DONE;
                end
            end else if (arm) begin
                m_len = cfg_capture_len; m_tmo = cfg_timeout;
                m_waited = 0; m_beats = 0;
                m_phase = (m_len == 0) ? P_DONE : (cfg_ext_sync_en ? P_WAIT : P_CAP);
            end
        end
    end

    // compare on the falling edge, well away from the active edge
    always @(negedge clk) begin
        logic [NCH-1:0] exp_vo;
        exp_vo = (m_phase == P_CAP && link_valid) ? adc_valid_in : '0;
        check("state_debug", state_debug, m_phase);
        check("sync_armed", sync_armed, m_phase == P_WAIT);
        check("capture_active", capture_active, m_phase == P_CAP);
        check("capture_done", capture_done, m_phase == P_DONE);
        check("timeout_err", timeout_err, m_phase == P_TMO);
        check("beat_count", beat_count, m_beats);
        check("adc_valid_out", adc_valid_out, exp_vo);
        if (adc_valid_out != '0) vo_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_arm(input bit ext, input int len, input int tmo);
        cfg_ext_sync_en = ext; cfg_capture_len = len; cfg_timeout = tmo;
        arm = 1'b1; vo_cnt = 0;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        rst = 1'b1; arm = 0; abort = 0; cfg_ext_sync_en = 0;
        cfg_capture_len = 0; cfg_timeout = 0; adc_sync_in = 0;
        link_valid = 0; adc_valid_in = '0;
        #23;
        check("rst_state", state_debug, 0);
        check("rst_beats", beat_count, 0);
        check("rst_vo", adc_valid_out, 0);
        @(negedge clk); rst = 1'b0;
        tick();

        // immediate capture, 4 beats
        link_valid = 1; adc_valid_in = 4'hF;
        do_arm(0, 4, 0);
        tick(6);
        check("t1_vo_cycles", vo_cnt, 4);
        check("t1_done", capture_done, 1);
        check("t1_beats", beat_count, 4);

        // external sync, no timeout, toggling link_valid
        link_valid = 0;
        do_arm(1, 3, 0);
        tick(9);
        check("t2_armed", sync_armed, 1);
        adc_sync_in = 1; tick(); adc_sync_in = 0;
        check("t2_cap", state_debug, 2);
        link_valid = 1; tick(); link_valid = 0; tick();
        link_valid = 1; tick(); link_valid = 0; tick();
        link_valid = 1; tick(); link_valid = 0;
        check("t2_done", capture_done, 1);
        check("t2_beats", beat_count, 3);
        check("t2_vo_cycles", vo_cnt, 3);

        // timeout after 5 cycles, no edge
        link_valid = 1;
        do_arm(1, 2, 5);
        for (int i = 0; i < 5; i++) begin
            check("t3_armed", sync_armed, 1);
            tick();
        end
        check("t3_tmo", timeout_err, 1);
        check("t3_vo_cycles", vo_cnt, 0);
        // edge lands exactly on the timeout cycle: edge wins
        do_arm(1, 5, 5);
        tick(4);
        adc_sync_in = 1; tick(); adc_sync_in = 0;
        check("t3b_cap", state_debug, 2);
        tick(6);
        check("t3b_done", capture_done, 1);

        // zero length, then re-arm from DONE
        do_arm(0, 0, 0);
        check("t4_done", capture_done, 1);
        check("t4_vo_cycles", vo_cnt, 0);
        do_arm(0, 2, 0);
        check("t4_rearm_cap", capture_active, 1);
        check("t4_rearm_beats", beat_count, 0);
        tick(2);
        check("t4_beats", beat_count, 2);

        // arm ignored mid-capture, abort at beat 2 of 8
        do_arm(0, 8, 0);
        cfg_capture_len = 3; arm = 1; tick(); arm = 0;
        tick();
        check("t5_beats", beat_count, 2);
        check("t5_cap", state_debug, 2);
        link_valid = 0; abort = 1; tick(); abort = 0; link_valid = 1;
        check("t5_idle", state_debug, 0);
        check("t5_vo", adc_valid_out, 0);
        check("t5_beats_hold", beat_count, 2);

        // async reset mid-capture
        do_arm(0, 8, 0);
        tick(3);
        #2 rst = 1; #1;
        check("t6_state", state_debug, 0);
        check("t6_beats", beat_count, 0);
        check("t6_vo", adc_valid_out, 0);
        check("t6_active", capture_active, 0);
        @(negedge clk); #2 rst = 0;
        tick();
        do_arm(0, 2, 0);
        tick(2);
        check("t6_done", capture_done, 1);
        check("t6_beats_end", beat_count, 2);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            arm             = ($urandom_range(0, 11) == 0);
            abort           = ($urandom_range(0, 47) == 0);
            cfg_ext_sync_en = $urandom_range(0, 1);
            cfg_capture_len = $urandom_range(0, 6);
            cfg_timeout     = $urandom_range(0, 8);
            if ($urandom_range(0, 5) == 0) adc_sync_in = ~adc_sync_in;
            link_valid      = abort ? 1'b0 : 1'($urandom_range(0, 1));
            adc_valid_in    = NCH'($urandom);
            tick();
        end
        arm = 0; abort = 0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
